// File: rtl/cpu_pkg.sv
// Shared CPU constants and types used by the register bank and its dump engine.
package cpu_pkg;

  localparam int unsigned XLEN   = 64;
  localparam int unsigned SEL_W  = 6;
  localparam int unsigned NREGS  = 64;
  localparam int unsigned NBYTES = XLEN / 8;
  localparam int unsigned CNT_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  typedef logic [XLEN-1:0]  word_t;
  typedef logic [SEL_W-1:0] regsel_t;

  typedef enum logic [1:0] {
    DUMP_IDLE,
    DUMP_SEND,
    DUMP_DONE
  } dump_state_t;

endpackage

// File: rtl/regbank_if.sv
// Dump request and byte-serial bus between the register bank and its consumer.
interface regbank_if;
  import cpu_pkg::*;

  logic       dump_req;
  regsel_t    dump_sel;
  logic       dump_busy;
  logic [7:0] bus_out;
  logic       bus_valid;
  logic       bus_ready;

  modport master (
    output dump_req, dump_sel, bus_ready,
    input  dump_busy, bus_out, bus_valid
  );

  modport slave (
    input  dump_req, dump_sel, bus_ready,
    output dump_busy, bus_out, bus_valid
  );

endinterface

// File: rtl/regbank_dump.sv
// Dump engine: snapshots one register and streams it LSB byte first under valid/ready.
module regbank_dump
  import cpu_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       dump_req,
  input  word_t      fwd_val,
  input  logic       bus_ready,
  output logic [7:0] bus_out,
  output logic       bus_valid,
  output logic       dump_busy
);

  localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(NBYTES - 1);

  dump_state_t      state_q, state_d;
  word_t            snap_q, snap_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       out_q, out_d;
  logic             valid_q, valid_d;

  // The snapshot holds only bytes not yet presented, so the next byte is always snap_q[7:0].
  always_comb begin
    state_d = state_q;
    snap_d  = snap_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    valid_d = valid_q;
    case (state_q)
      DUMP_IDLE: begin
        if (dump_req) begin
          out_d   = fwd_val[7:0];
          snap_d  = fwd_val >> 8;
          cnt_d   = '0;
          valid_d = 1'b1;
          state_d = DUMP_SEND;
        end
      end
      DUMP_SEND: begin
        if (valid_q && bus_ready) begin
          if (cnt_q == LAST_BYTE) begin
            valid_d = 1'b0;
            state_d = DUMP_DONE;
          end else begin
            cnt_d  = cnt_q + CNT_W'(1);
            out_d  = snap_q[7:0];
            snap_d = snap_q >> 8;
          end
        end
      end
      DUMP_DONE: state_d = DUMP_IDLE;
      default:   state_d = DUMP_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= DUMP_IDLE;
      snap_q  <= '0;
      cnt_q   <= '0;
      out_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      snap_q  <= snap_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      valid_q <= valid_d;
    end
  end

  assign bus_out   = out_q;
  assign bus_valid = valid_q;
  assign dump_busy = (state_q != DUMP_IDLE);

endmodule

// File: rtl/regbank.sv
// Architectural register file: one write port, two registered read ports with
// write-to-read forwarding, and a byte-serial dump engine.
module regbank
  import cpu_pkg::*;
(
  input  logic    clk,
  input  logic    rst_n,
  input  logic    regbank_we,
  input  regsel_t regbank_sel,
  input  word_t   regbank_valin,
  input  regsel_t rd_a_sel,
  output word_t   rd_a_val,
  input  regsel_t rd_b_sel,
  output word_t   rd_b_val,
  regbank_if.slave dump_if
);

  word_t regs_q [NREGS];
  word_t regs_d [NREGS];
  word_t rd_a_q, rd_a_d;
  word_t rd_b_q, rd_b_d;
  word_t dump_fwd;

  always_comb begin
    regs_d = regs_q;
    if (regbank_we) regs_d[regbank_sel] = regbank_valin;
  end

  // A same-cycle write to the selected index wins over the stored value.
  always_comb begin
    rd_a_d   = regs_q[rd_a_sel];
    rd_b_d   = regs_q[rd_b_sel];
    dump_fwd = regs_q[dump_if.dump_sel];
    if (regbank_we && (regbank_sel == rd_a_sel))         rd_a_d   = regbank_valin;
    if (regbank_we && (regbank_sel == rd_b_sel))         rd_b_d   = regbank_valin;
    if (regbank_we && (regbank_sel == dump_if.dump_sel)) dump_fwd = regbank_valin;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NREGS; i++) regs_q[i] <= '0;
      rd_a_q <= '0;
      rd_b_q <= '0;
    end else begin
      regs_q <= regs_d;
      rd_a_q <= rd_a_d;
      rd_b_q <= rd_b_d;
    end
  end

  assign rd_a_val = rd_a_q;
  assign rd_b_val = rd_b_q;

  regbank_dump u_dump (
    .clk       (clk),
    .rst_n     (rst_n),
    .dump_req  (dump_if.dump_req),
    .fwd_val   (dump_fwd),
    .bus_ready (dump_if.bus_ready),
    .bus_out   (dump_if.bus_out),
    .bus_valid (dump_if.bus_valid),
    .dump_busy (dump_if.dump_busy)
  );

endmodule
